// File: rtl/host_lcd_pkg.sv
// host_lcd_pkg: FSM states, HD44780 command codes and character helpers shared by the LCD driver.
package host_lcd_pkg;
    typedef enum logic [2:0] {
        ST_POWERUP, ST_INIT, ST_CMD1, ST_ROW1, ST_CMD2, ST_ROW2, ST_IDLE
    } lcd_state_t;

    typedef enum logic [1:0] {WR_IDLE, WR_SETUP, WR_EN, WR_GAP} wr_phase_t;

    localparam logic [7:0] CMD_FUNCSET = 8'h38;
    localparam logic [7:0] CMD_DISPON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_LINE1   = 8'h80;
    localparam logic [7:0] CMD_LINE2   = 8'hC0;
    localparam logic [7:0] CHAR_SPACE  = 8'h20;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        return i == 2'd0 ? CMD_FUNCSET : i == 2'd1 ? CMD_DISPON : i == 2'd2 ? CMD_ENTRY : CMD_CLEAR;
    endfunction

    // Index 0 is the leftmost character; non-printables are shown as a space.
    function automatic logic [7:0] row_char(input logic [127:0] row, input logic [3:0] i);
        logic [7:0] c;
        c = row[{~i, 3'b000} +: 8];
        return (c < 8'h20 || c > 8'h7E) ? CHAR_SPACE : c;
    endfunction
endpackage

// File: rtl/host_lcd_driver_byte_writer.sv
// lcd_byte_writer: one HD44780 write as SETUP, EN_CYC enable-high cycles, then a low GAP (longer after clear).
module lcd_byte_writer
    import host_lcd_pkg::*;
#(
    parameter int EN_CYC       = 1,
    parameter int GAP_CYC      = 1,
    parameter int CLR_WAIT_CYC = 20,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       done,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);
    wr_phase_t        ph;
    logic [CNT_W-1:0] cnt;
    logic             is_clr;
    logic [CNT_W-1:0] gap_last;
    logic             accept;

    assign gap_last = is_clr ? CNT_W'(GAP_CYC + CLR_WAIT_CYC - 1) : CNT_W'(GAP_CYC - 1);
    assign done     = ph == WR_GAP && cnt == gap_last;
    // The final GAP cycle counts as idle so back-to-back bytes need no dead cycle.
    assign accept   = start && (ph == WR_IDLE || done);

    always_ff @(posedge clk) begin
        if (rst) begin
            ph       <= WR_IDLE;
            cnt      <= '0;
            is_clr   <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else if (accept) begin
            ph       <= WR_SETUP;
            cnt      <= '0;
            is_clr   <= !rs && data == CMD_CLEAR;
            lcd_en   <= 1'b0;
            lcd_rs   <= rs;
            lcd_data <= data;
        end else begin
            case (ph)
                WR_SETUP: begin
                    ph     <= WR_EN;
                    cnt    <= '0;
                    lcd_en <= 1'b1;
                end
                WR_EN: begin
                    if (cnt == CNT_W'(EN_CYC - 1)) begin
                        ph     <= WR_GAP;
                        cnt    <= '0;
                        lcd_en <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_GAP: begin
                    if (done) ph <= WR_IDLE;
                    else cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/host_lcd_driver.sv
// host_lcd_driver: powers up an HD44780 panel and refreshes two 16-char rows from a tear-free snapshot.
module host_lcd_driver
    import host_lcd_pkg::*;
#(
    parameter int POWERUP_CYC  = 200,
    parameter int EN_CYC       = 1,
    parameter int GAP_CYC      = 1,
    parameter int CLR_WAIT_CYC = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] host_row1,
    input  logic [127:0] host_row2,
    output logic         lcd_en,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_data,
    output logic         lcd_busy,
    output logic         frame_done
);
    localparam int GAP_MAX = GAP_CYC + CLR_WAIT_CYC;
    localparam int CNT_MAX = POWERUP_CYC > GAP_MAX ? (POWERUP_CYC > EN_CYC ? POWERUP_CYC : EN_CYC)
                                                   : (GAP_MAX > EN_CYC ? GAP_MAX : EN_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    lcd_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       idx;
    logic [3:0]       nidx;
    logic [127:0]     row1_s;
    logic [127:0]     row2_s;
    logic             changed;
    logic             snap;
    logic             wr_start;
    logic             wr_rs;
    logic [7:0]       wr_data;
    logic             wr_done;

    assign nidx     = idx + 4'd1;
    assign changed  = host_row1 != row1_s || host_row2 != row2_s;
    assign snap     = (state == ST_INIT && wr_done && idx == 4'd3) || (state == ST_IDLE && changed);
    assign lcd_rw   = 1'b0;
    assign lcd_busy = state != ST_IDLE;

    // Next byte is chosen so its SETUP begins on the same edge as the state it belongs to.
    always_comb begin
        wr_start = 1'b0;
        wr_rs    = 1'b0;
        wr_data  = 8'h00;
        case (state)
            ST_POWERUP: begin
                wr_start = cnt == CNT_W'(POWERUP_CYC - 1);
                wr_data  = CMD_FUNCSET;
            end
            ST_INIT: begin
                wr_start = wr_done;
                wr_data  = idx == 4'd3 ? CMD_LINE1 : init_cmd(nidx[1:0]);
            end
            ST_CMD1: begin
                wr_start = wr_done;
                wr_rs    = 1'b1;
                wr_data  = row_char(row1_s, idx);
            end
            ST_ROW1: begin
                wr_start = wr_done;
                wr_rs    = idx != 4'd15;
                wr_data  = idx == 4'd15 ? CMD_LINE2 : row_char(row1_s, nidx);
            end
            ST_CMD2: begin
                wr_start = wr_done;
                wr_rs    = 1'b1;
                wr_data  = row_char(row2_s, idx);
            end
            ST_ROW2: begin
                wr_start = wr_done && idx != 4'd15;
                wr_rs    = 1'b1;
                wr_data  = row_char(row2_s, nidx);
            end
            ST_IDLE: begin
                wr_start = changed;
                wr_data  = CMD_LINE1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_POWERUP;
            cnt        <= '0;
            idx        <= '0;
            row1_s     <= {16{CHAR_SPACE}};
            row2_s     <= {16{CHAR_SPACE}};
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (snap) begin
                row1_s <= host_row1;
                row2_s <= host_row2;
            end
            case (state)
                ST_POWERUP: begin
                    if (wr_start) state <= ST_INIT;
                    else cnt <= cnt + 1'b1;
                end
                ST_INIT: begin
                    if (wr_done) begin
                        idx <= idx == 4'd3 ? 4'd0 : nidx;
                        if (idx == 4'd3) state <= ST_CMD1;
                    end
                end
                ST_CMD1: if (wr_done) state <= ST_ROW1;
                ST_ROW1: begin
                    if (wr_done) begin
                        idx <= nidx;
                        if (idx == 4'd15) state <= ST_CMD2;
                    end
                end
                ST_CMD2: if (wr_done) state <= ST_ROW2;
                ST_ROW2: begin
                    if (wr_done) begin
                        idx <= nidx;
                        if (idx == 4'd15) begin
                            state      <= ST_IDLE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                ST_IDLE: if (changed) state <= ST_CMD1;
                default: state <= ST_POWERUP;
            endcase
        end
    end

    lcd_byte_writer #(
        .EN_CYC      (EN_CYC),
        .GAP_CYC     (GAP_CYC),
        .CLR_WAIT_CYC(CLR_WAIT_CYC),
        .CNT_W       (CNT_W)
    ) u_writer (
        .clk     (clk),
        .rst     (rst),
        .start   (wr_start),
        .rs      (wr_rs),
        .data    (wr_data),
        .done    (wr_done),
        .lcd_en  (lcd_en),
        .lcd_rs  (lcd_rs),
        .lcd_data(lcd_data)
    );
endmodule

// File: tb/tb_host_lcd_driver.sv
// tb_host_lcd_driver: scoreboard bench; the model lists the byte stream each frame should produce.
module tb_host_lcd_driver;
    localparam int P = 4, E = 1, G = 1, C = 5;
    localparam int LOW = 1 + G, LOW_CLR = 1 + G + C, FRAME_CYC = 34 * (1 + E + G);

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         low;
    } exp_t;

    logic         tb_clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] host_row1 = '0;
    logic [127:0] host_row2 = '0;
    logic         lcd_en, lcd_rs, lcd_rw, lcd_busy, frame_done;
    logic [7:0]   lcd_data;

    exp_t exp_q[$];
    int   total = 0, bad = 0, cyc = 0, rises = 0, last_cmd1 = 0;

    host_lcd_driver #(.POWERUP_CYC(P), .EN_CYC(E), .GAP_CYC(G), .CLR_WAIT_CYC(C)) dut (
        .clk       (tb_clk),
        .rst       (rst),
        .host_row1 (host_row1),
        .host_row2 (host_row2),
        .lcd_en    (lcd_en),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data),
        .lcd_busy  (lcd_busy),
        .frame_done(frame_done)
    );

    always #5 tb_clk = ~tb_clk;
    always @(posedge tb_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [7:0] tb_char(input logic [127:0] row, input int i);
        logic [7:0] c;
        c = row[8 * (15 - i) +: 8];
        return (c >= 8'h20 && c <= 8'h7E) ? c : 8'h20;
    endfunction

    task automatic push(input logic rs, input logic [7:0] data, input int low);
        exp_t e;
        e.rs = rs;
        e.data = data;
        e.low = low;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push(1'b0, 8'h38, 0);
        push(1'b0, 8'h0C, LOW);
        push(1'b0, 8'h06, LOW);
        push(1'b0, 8'h01, LOW);
    endtask

    task automatic push_frame(input logic [127:0] r1, input logic [127:0] r2, input int first_low);
        push(1'b0, 8'h80, first_low);
        for (int i = 0; i < 16; i++) push(1'b1, tb_char(r1, i), LOW);
        push(1'b0, 8'hC0, LOW);
        for (int i = 0; i < 16; i++) push(1'b1, tb_char(r2, i), LOW);
    endtask

    task automatic wait_fd(input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(posedge tb_clk);
            #2;
            if (frame_done) begin
                at = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL frame_done_timeout: got no pulse, expected one within %0d cycles", budget);
    endtask

    task automatic wait_rises(input int target, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(posedge tb_clk);
            #2;
            if (rises >= target) return;
        end
        total++;
        bad++;
        $display("FAIL byte_timeout: got %0d strobes, expected %0d", rises, target);
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_en"}, lcd_en, 0);
        check({tag, "_rs"}, lcd_rs, 0);
        check({tag, "_rw"}, lcd_rw, 0);
        check({tag, "_data"}, lcd_data, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_busy"}, lcd_busy, 1);
    endtask

    // Monitor: pops one expected byte per enable strobe and checks strobe/gap timing.
    initial begin
        logic prev_en;
        int   hi_cnt, lo_cnt;
        exp_t e;
        prev_en = 1'b0;
        hi_cnt = 0;
        lo_cnt = 0;
        forever begin
            @(negedge tb_clk);
            if (rst) begin
                prev_en = 1'b0;
                hi_cnt = 0;
                lo_cnt = 0;
            end else begin
                if (lcd_en && !prev_en) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got rs=%0b data=%02h, expected no byte", lcd_rs, lcd_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", {lcd_rs, lcd_data}, {e.rs, e.data});
                        if (e.low != 0) check("low_before_strobe", lo_cnt, e.low);
                    end
                    check("rw", lcd_rw, 0);
                    if (!lcd_rs && lcd_data == 8'h80) last_cmd1 = cyc - 1;
                    rises++;
                    hi_cnt = 0;
                end
                if (!lcd_en && prev_en) begin
                    check("en_width", hi_cnt, E);
                    lo_cnt = 0;
                end
                if (lcd_en) hi_cnt++;
                else lo_cnt++;
                if (frame_done) check("frame_cycles", cyc - last_cmd1, FRAME_CYC);
                prev_en = lcd_en;
            end
        end
    end

    initial begin
        logic [127:0] r1, r2;
        int fd_a, fd_b, base, viol;
        r1 = {"HELLO", {11{8'h20}}};
        r2 = {16{8'h20}};
        host_row1 = r1;
        host_row2 = r2;
        repeat (2) @(posedge tb_clk);
        #1;
        reset_check("reset");
        #1;
        push_init();
        push_frame(r1, r2, LOW_CLR);
        rst = 1'b0;
        for (int i = 0; i < P; i++) begin
            @(posedge tb_clk);
            #2;
            check("powerup_en_low", lcd_en, 0);
        end
        wait_fd(400, fd_a);

        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge tb_clk);
            #2;
            if (lcd_busy || lcd_en) viol++;
        end
        check("idle_quiet_violations", viol, 0);

        r2[127:120] = 8'h0A;
        host_row2 = r2;
        push_frame(r1, r2, 0);
        wait_fd(300, fd_a);

        r2 = {"LINE TWO", {8{8'h2E}}};
        host_row2 = r2;
        base = rises;
        push_frame(r1, r2, 0);
        wait_rises(base + 20, 200);
        r1[127:120] = 8'h57;
        host_row1 = r1;
        push_frame(r1, r2, 0);
        wait_fd(300, fd_a);
        wait_fd(300, fd_b);
        check("cmd1_after_frame_done", last_cmd1 - fd_a, 1);

        r1 = {"RESET MID ROW1!!"};
        host_row1 = r1;
        base = rises;
        push_frame(r1, r2, 0);
        wait_rises(base + 8, 200);
        @(posedge tb_clk);
        @(posedge tb_clk);
        #2;
        rst = 1'b1;
        @(posedge tb_clk);
        #1;
        reset_check("midbyte_reset");
        #1;
        exp_q.delete();
        push_init();
        push_frame(r1, r2, LOW_CLR);
        @(posedge tb_clk);
        #2;
        rst = 1'b0;
        wait_fd(400, fd_a);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) begin
                r1[8 * i +: 8] = 8'($urandom_range(0, 255));
                r2[8 * i +: 8] = 8'($urandom_range(0, 255));
            end
            host_row1 = r1;
            host_row2 = r2;
            push_frame(r1, r2, 0);
            wait_fd(300, fd_a);
        end

        repeat (5) @(posedge tb_clk);
        #2;
        check("idle_busy", lcd_busy, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
